// File: rtl/m_cycle_sequencer.sv
// Machine-cycle sequencer: issues one latched m-cycle code per non-stalled clock,
// with conditional early exit, prioritised interrupt entry and HALT/wake-up.
module m_cycle_sequencer #(
   parameter int               MC_W     = 5,
   parameter int               DEPTH    = 8,
   parameter int               NUM_IRQ  = 5,
   parameter int               IRQ_LEN  = 4,
   parameter logic [IRQ_LEN*MC_W-1:0] IRQ_SEQ = '0,
   parameter logic [7:0]       VEC_BASE = 8'h40,
   parameter logic [7:0]       VEC_STEP = 8'h08,
   localparam int              LEN_W    = $clog2(DEPTH + 1),
   localparam int              STEP_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int              IRQ_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    seq_load,
   input  logic [LEN_W-1:0]        seq_len,
   input  logic [DEPTH*MC_W-1:0]   seq_cycles,
   input  logic                    cond_en,
   input  logic [STEP_W-1:0]       cond_idx,
   input  logic                    cond_true,
   input  logic                    stall,
   input  logic                    ime,
   input  logic [NUM_IRQ-1:0]      irq_pending,
   input  logic                    halt_req,
   output logic [MC_W-1:0]         m_cycle,
   output logic                    m_cycle_valid,
   output logic [STEP_W-1:0]       step_idx,
   output logic                    op_done,
   output logic                    fetch_req,
   output logic                    irq_active,
   output logic [NUM_IRQ-1:0]      irq_ack,
   output logic [7:0]              rst_vector,
   output logic                    halted
);

   typedef enum logic [2:0] {
      ST_BOOT = 3'd0,
      ST_IDLE = 3'd1,
      ST_RUN  = 3'd2,
      ST_IRQ  = 3'd3,
      ST_HALT = 3'd4
   } state_t;

   state_t                  state_r, state_nx;
   logic [STEP_W-1:0]       step_r, step_nx;
   logic [LEN_W-1:0]        len_r;
   logic [DEPTH*MC_W-1:0]   seq_r;
   logic                    cond_en_r;
   logic [STEP_W-1:0]       cond_idx_r;
   logic [IRQ_W-1:0]        irq_idx_r;
   logic [7:0]              vec_r;
   logic                    ack_done_r;
   logic                    load_s, take_irq_s, run_last_s, irq_last_s;
   logic [IRQ_W-1:0]        irq_sel_s;

   // Lowest set bit wins: source 0 has the highest priority.
   function automatic logic [IRQ_W-1:0] lowest_irq(input logic [NUM_IRQ-1:0] p);
      lowest_irq = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (p[i]) lowest_irq = IRQ_W'(i);
      end
   endfunction

   function automatic logic [7:0] vec_for(input logic [IRQ_W-1:0] idx);
      vec_for = VEC_BASE + VEC_STEP * 8'(idx);
   endfunction

   assign irq_sel_s  = lowest_irq(irq_pending);
   assign run_last_s = (LEN_W'(step_r) == len_r - LEN_W'(1'b1)) ||
                       (cond_en_r && (step_r == cond_idx_r) && !cond_true);
   assign irq_last_s = (step_r == STEP_W'(IRQ_LEN - 1));

   // Next-state, capture strobes and all outputs; everything reads 0 while reset is high.
   always_comb begin
      state_nx      = state_r;
      step_nx       = step_r;
      load_s        = 1'b0;
      take_irq_s    = 1'b0;
      m_cycle       = '0;
      m_cycle_valid = 1'b0;
      step_idx      = '0;
      op_done       = 1'b0;
      fetch_req     = 1'b0;
      irq_active    = 1'b0;
      irq_ack       = '0;
      rst_vector    = 8'h00;
      halted        = 1'b0;
      if (!reset) begin
         rst_vector = vec_r;
         case (state_r)
            ST_BOOT: state_nx = ST_IDLE;
            ST_IDLE: begin
               fetch_req = 1'b1;
               if (stall) begin
                  state_nx = ST_IDLE;
               end else if (ime && (|irq_pending)) begin
                  take_irq_s = 1'b1;
                  step_nx    = '0;
                  state_nx   = ST_IRQ;
               end else if (halt_req) begin
                  state_nx = ST_HALT;
               end else if (seq_load) begin
                  if (seq_len != LEN_W'(1'b0)) begin
                     load_s   = 1'b1;
                     step_nx  = '0;
                     state_nx = ST_RUN;
                  end else begin
                     op_done = 1'b1;
                  end
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            ST_RUN: begin
               m_cycle_valid = 1'b1;
               m_cycle       = seq_r[step_r*MC_W +: MC_W];
               step_idx      = step_r;
               if (!stall) begin
                  if (run_last_s) begin
                     op_done  = 1'b1;
                     state_nx = ST_IDLE;
                  end else begin
                     step_nx = step_r + STEP_W'(1'b1);
                  end
               end else begin
                  step_nx = step_r;
               end
            end
            ST_IRQ: begin
               m_cycle_valid = 1'b1;
               irq_active    = 1'b1;
               m_cycle       = IRQ_SEQ[step_r*MC_W +: MC_W];
               step_idx      = step_r;
               irq_ack       = ack_done_r ? '0 : (NUM_IRQ'(1'b1) << irq_idx_r);
               if (!stall) begin
                  if (irq_last_s) begin
                     op_done  = 1'b1;
                     state_nx = ST_IDLE;
                  end else begin
                     step_nx = step_r + STEP_W'(1'b1);
                  end
               end else begin
                  step_nx = step_r;
               end
            end
            ST_HALT: begin
               halted = 1'b1;
               if (|irq_pending) begin
                  if (ime) begin
                     take_irq_s = 1'b1;
                     step_nx    = '0;
                     state_nx   = ST_IRQ;
                  end else begin
                     state_nx = ST_IDLE;
                  end
               end else begin
                  state_nx = ST_HALT;
               end
            end
            default: state_nx = ST_BOOT;
         endcase
      end else begin
         state_nx = ST_BOOT;
      end
   end

   // State, step counter and latched instruction/interrupt context.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_BOOT;
         step_r     <= '0;
         len_r      <= '0;
         seq_r      <= '0;
         cond_en_r  <= 1'b0;
         cond_idx_r <= '0;
         irq_idx_r  <= '0;
         vec_r      <= 8'h00;
         ack_done_r <= 1'b0;
      end else begin
         state_r <= state_nx;
         step_r  <= step_nx;
         if (load_s) begin
            seq_r      <= seq_cycles;
            len_r      <= seq_len;
            cond_en_r  <= cond_en && (LEN_W'(cond_idx) < seq_len);
            cond_idx_r <= cond_idx;
         end
         // ack fires only on the first presentation of IRQ entry 0.
         if (take_irq_s) begin
            irq_idx_r  <= irq_sel_s;
            vec_r      <= vec_for(irq_sel_s);
            ack_done_r <= 1'b0;
         end else if (state_r == ST_IRQ) begin
            ack_done_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// Scoreboard bench for m_cycle_sequencer: per-cycle stimulus and expected outputs are
// queued together and compared on the falling edge.
module tb_m_cycle_sequencer;

   logic        clk = 1'b0;
   logic        reset, seq_load, cond_en, cond_true, stall, ime, halt_req;
   logic [3:0]  seq_len;
   logic [39:0] seq_cycles;
   logic [2:0]  cond_idx, step_idx;
   logic [4:0]  irq_pending, m_cycle, irq_ack;
   logic        m_cycle_valid, op_done, fetch_req, irq_active, halted;
   logic [7:0]  rst_vector;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic rst; logic ld; logic [3:0] len; logic [39:0] cyc; logic cen;
      logic [2:0] cidx; logic ct; logic st; logic ime; logic [4:0] irq; logic halt;
   } stim_t;

   typedef struct packed {
      logic [4:0] m; logic v; logic [2:0] s; logic od; logic fr; logic ia;
      logic [4:0] ack; logic [7:0] vec; logic h;
   } outs_t;

   stim_t sq[$];
   outs_t eq[$];

   localparam logic [39:0] C3 = {25'd0, 5'd9, 5'd7, 5'd3};
   localparam logic [39:0] C4 = {20'd0, 5'd4, 5'd3, 5'd2, 5'd1};
   localparam logic [39:0] C5 = {15'd0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
   localparam stim_t       SI = '0;

   m_cycle_sequencer #(
      .IRQ_SEQ({5'd24, 5'd23, 5'd22, 5'd21})
   ) dut (
      .clk(clk), .reset(reset), .seq_load(seq_load), .seq_len(seq_len),
      .seq_cycles(seq_cycles), .cond_en(cond_en), .cond_idx(cond_idx),
      .cond_true(cond_true), .stall(stall), .ime(ime), .irq_pending(irq_pending),
      .halt_req(halt_req), .m_cycle(m_cycle), .m_cycle_valid(m_cycle_valid),
      .step_idx(step_idx), .op_done(op_done), .fetch_req(fetch_req),
      .irq_active(irq_active), .irq_ack(irq_ack), .rst_vector(rst_vector),
      .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic stim_t S(input logic rst, input logic ld, input logic [3:0] len,
                               input logic [39:0] cyc, input logic cen, input logic [2:0] cidx,
                               input logic ct, input logic st, input logic im,
                               input logic [4:0] irq, input logic hlt);
      S = {rst, ld, len, cyc, cen, cidx, ct, st, im, irq, hlt};
   endfunction

   function automatic outs_t O(input logic [4:0] m, input logic v, input logic [2:0] s,
                               input logic od, input logic fr, input logic ia,
                               input logic [4:0] ack, input logic [7:0] vec, input logic h);
      O = {m, v, s, od, fr, ia, ack, vec, h};
   endfunction

   function automatic outs_t observed();
      observed = {m_cycle, m_cycle_valid, step_idx, op_done, fetch_req, irq_active,
                  irq_ack, rst_vector, halted};
   endfunction

   function automatic void push(input stim_t s, input outs_t e);
      sq.push_back(s);
      eq.push_back(e);
   endfunction

   task automatic apply(input stim_t s);
      reset = s.rst; seq_load = s.ld; seq_len = s.len; seq_cycles = s.cyc;
      cond_en = s.cen; cond_idx = s.cidx; cond_true = s.ct; stall = s.st;
      ime = s.ime; irq_pending = s.irq; halt_req = s.halt;
   endtask

   task automatic test_reset();
      outs_t e;
      push(S(1,0,0,0,0,0,0,0,0,5'd0,0), O(0,0,0,0,0,0,0,8'h00,0));
      push(SI,                          O(0,0,0,0,0,0,0,8'h00,0));
      push(SI,                          O(0,0,0,0,1,0,0,8'h00,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL reset cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_basic();
      outs_t e;
      push(S(0,1,4'd3,C3,0,0,0,0,0,5'd0,0), O(0,0,0,0,1,0,0,8'h00,0));
      push(SI, O(3,1,0,0,0,0,0,8'h00,0));
      push(SI, O(7,1,1,0,0,0,0,8'h00,0));
      push(SI, O(9,1,2,1,0,0,0,8'h00,0));
      push(SI, O(0,0,0,0,1,0,0,8'h00,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL basic cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      outs_t e;
      push(S(0,1,4'd3,C3,0,0,0,0,0,5'd0,0), O(0,0,0,0,1,0,0,8'h00,0));
      push(SI,                          O(3,1,0,0,0,0,0,8'h00,0));
      push(S(0,0,0,0,0,0,0,1,0,5'd0,0), O(7,1,1,0,0,0,0,8'h00,0));
      push(S(0,0,0,0,0,0,0,1,0,5'd0,0), O(7,1,1,0,0,0,0,8'h00,0));
      push(SI,                          O(7,1,1,0,0,0,0,8'h00,0));
      push(SI,                          O(9,1,2,1,0,0,0,8'h00,0));
      push(SI,                          O(0,0,0,0,1,0,0,8'h00,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL stall cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_cond();
      outs_t e;
      stim_t ct0, ct1;
      ct0 = SI;
      ct1 = SI; ct1.ct = 1'b1;
      // condition false at entry 1: early exit
      push(S(0,1,4'd5,C5,1,3'd1,0,0,0,5'd0,0), O(0,0,0,0,1,0,0,8'h00,0));
      push(ct0, O(1,1,0,0,0,0,0,8'h00,0));
      push(ct0, O(2,1,1,1,0,0,0,8'h00,0));
      push(ct0, O(0,0,0,0,1,0,0,8'h00,0));
      // condition true: full length
      push(S(0,1,4'd5,C5,1,3'd1,1,0,0,5'd0,0), O(0,0,0,0,1,0,0,8'h00,0));
      push(ct1, O(1,1,0,0,0,0,0,8'h00,0));
      push(ct1, O(2,1,1,0,0,0,0,8'h00,0));
      push(ct1, O(3,1,2,0,0,0,0,8'h00,0));
      push(ct1, O(4,1,3,0,0,0,0,8'h00,0));
      push(ct1, O(5,1,4,1,0,0,0,8'h00,0));
      push(ct1, O(0,0,0,0,1,0,0,8'h00,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL cond cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_boundary();
      outs_t e;
      // stall in IDLE masks load, interrupt and halt
      push(S(0,1,4'd3,C3,0,0,0,1,1,5'b00001,1), O(0,0,0,0,1,0,0,8'h00,0));
      // zero-length load: op_done in the same cycle, stay in IDLE
      push(S(0,1,4'd0,C3,0,0,0,0,0,5'd0,0),     O(0,0,0,1,1,0,0,8'h00,0));
      push(SI,                                  O(0,0,0,0,1,0,0,8'h00,0));
      // cond_idx beyond length behaves as unconditional
      push(S(0,1,4'd2,C5,1,3'd5,0,0,0,5'd0,0),  O(0,0,0,0,1,0,0,8'h00,0));
      push(SI, O(1,1,0,0,0,0,0,8'h00,0));
      push(SI, O(2,1,1,1,0,0,0,8'h00,0));
      push(SI, O(0,0,0,0,1,0,0,8'h00,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL boundary cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_irq();
      outs_t e;
      push(S(0,1,4'd3,C3,0,0,0,0,1,5'b10100,0), O(0,0,0,0,1,0,0,8'h00,0));
      push(S(0,0,0,0,0,0,0,0,1,5'b10100,0),     O(21,1,0,0,0,1,5'b00100,8'h50,0));
      push(S(0,0,0,0,0,0,0,0,1,5'b00001,0),     O(22,1,1,0,0,1,5'b00000,8'h50,0));
      push(S(0,0,0,0,0,0,0,0,1,5'b00001,0),     O(23,1,2,0,0,1,5'b00000,8'h50,0));
      push(S(0,0,0,0,0,0,0,0,1,5'b00001,0),     O(24,1,3,1,0,1,5'b00000,8'h50,0));
      // the sequence offered earlier is still pending and now loads
      push(S(0,1,4'd3,C3,0,0,0,0,0,5'd0,0),     O(0,0,0,0,1,0,0,8'h50,0));
      push(SI, O(3,1,0,0,0,0,0,8'h50,0));
      push(SI, O(7,1,1,0,0,0,0,8'h50,0));
      push(SI, O(9,1,2,1,0,0,0,8'h50,0));
      push(SI, O(0,0,0,0,1,0,0,8'h50,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL irq cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_irq_stall();
      outs_t e;
      push(S(0,0,0,0,0,0,0,0,1,5'b00010,0), O(0,0,0,0,1,0,0,8'h50,0));
      push(S(0,0,0,0,0,0,0,1,1,5'b00000,0), O(21,1,0,0,0,1,5'b00010,8'h48,0));
      push(S(0,0,0,0,0,0,0,1,1,5'b00000,0), O(21,1,0,0,0,1,5'b00000,8'h48,0));
      push(SI, O(21,1,0,0,0,1,5'b00000,8'h48,0));
      push(SI, O(22,1,1,0,0,1,5'b00000,8'h48,0));
      push(SI, O(23,1,2,0,0,1,5'b00000,8'h48,0));
      push(SI, O(24,1,3,1,0,1,5'b00000,8'h48,0));
      push(SI, O(0,0,0,0,1,0,0,8'h48,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL irq_stall cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt();
      outs_t e;
      // wake with ime=0: back to IDLE
      push(S(0,0,0,0,0,0,0,0,0,5'd0,1),     O(0,0,0,0,1,0,0,8'h48,0));
      push(SI,                              O(0,0,0,0,0,0,0,8'h48,1));
      push(S(0,0,0,0,0,0,0,0,0,5'b00001,0), O(0,0,0,0,0,0,0,8'h48,1));
      push(S(0,0,0,0,0,0,0,0,0,5'b00001,0), O(0,0,0,0,1,0,0,8'h48,0));
      push(SI,                              O(0,0,0,0,1,0,0,8'h48,0));
      // wake with ime=1: straight into IRQ; stall ignored while halted
      push(S(0,0,0,0,0,0,0,0,0,5'd0,1),     O(0,0,0,0,1,0,0,8'h48,0));
      push(S(0,0,0,0,0,0,0,1,0,5'd0,0),     O(0,0,0,0,0,0,0,8'h48,1));
      push(S(0,0,0,0,0,0,0,0,1,5'b00001,0), O(0,0,0,0,0,0,0,8'h48,1));
      push(SI, O(21,1,0,0,0,1,5'b00001,8'h40,0));
      push(SI, O(22,1,1,0,0,1,5'b00000,8'h40,0));
      push(SI, O(23,1,2,0,0,1,5'b00000,8'h40,0));
      push(SI, O(24,1,3,1,0,1,5'b00000,8'h40,0));
      push(SI, O(0,0,0,0,1,0,0,8'h40,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL halt cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      outs_t e;
      push(S(0,1,4'd4,C4,0,0,0,0,0,5'd0,0), O(0,0,0,0,1,0,0,8'h40,0));
      push(SI,                              O(1,1,0,0,0,0,0,8'h40,0));
      push(SI,                              O(2,1,1,0,0,0,0,8'h40,0));
      push(S(1,0,0,0,0,0,0,0,0,5'd0,0),     O(0,0,0,0,0,0,0,8'h00,0));
      push(SI,                              O(0,0,0,0,0,0,0,8'h00,0));
      push(SI,                              O(0,0,0,0,1,0,0,8'h00,0));
      push(SI,                              O(0,0,0,0,1,0,0,8'h00,0));
      for (int n = 0; sq.size() > 0; n++) begin
         apply(sq.pop_front()); @(negedge clk); e = eq.pop_front(); checks++;
         if (observed() !== e) begin
            failures++; $display("FAIL reset_mid cyc=%0d got=%h expected=%h", n, observed(), e);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_cond();
      test_boundary();
      test_irq();
      test_irq_stall();
      test_halt();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
